meta_array_ctrl: RTL

Sequencer and write arbiter for the 128-set x 8-way x 2-bit replacement/state metadata array (dual-port: one read port, one masked write port). After reset, and on request, it clears every set by sweeping the array. It then serves one read requester and arbitrates the single write port between a refill requester (one way) and an invalidate requester (any way mask). Writes that land in the same cycle as a read of the same set are forwarded into the read response.

---
 rtl/meta_array_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/meta_array_ctrl.sv
// Sweep-clear sequencer, read port driver and refill/invalidate write arbiter
// for the set-associative replacement/state metadata array.
module meta_array_ctrl #(
  parameter int unsigned SETS   = 128,
  parameter int unsigned WAYS   = 8,
  parameter int unsigned DATA_W = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush_all,
  output logic                        init_done,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [$clog2(SETS)-1:0]     rd_set,
  output logic                        rd_resp_valid,
  output logic [WAYS*DATA_W-1:0]      rd_resp_data,
  input  logic                        rf_valid,
  output logic                        rf_ready,
  input  logic [$clog2(SETS)-1:0]     rf_set,
  input  logic [$clog2(WAYS)-1:0]     rf_way,
  input  logic [DATA_W-1:0]           rf_data,
  input  logic                        iv_valid,
  output logic                        iv_ready,
  input  logic [$clog2(SETS)-1:0]     iv_set,
  input  logic [WAYS-1:0]             iv_maskOH,
  output logic [$clog2(SETS)-1:0]     arr_r_addr,
  input  logic [WAYS*DATA_W-1:0]      arr_r_data,
  output logic                        arr_w_en,
  output logic [$clog2(SETS)-1:0]     arr_w_addr,
  output logic [WAYS-1:0]             arr_w_maskOH,
  output logic [WAYS*DATA_W-1:0]      arr_w_data
);

  localparam int unsigned SetW  = $clog2(SETS);
  localparam int unsigned LineW = WAYS * DATA_W;

  typedef enum logic {StInit, StRun} state_e;

  state_e            st_q, st_d;
  logic [SetW-1:0]   init_cnt_q, init_cnt_d;
  logic              rr_q, rr_d;
  logic [SetW-1:0]   raddr_q;
  logic              resp_q;
  logic [LineW-1:0]  fwd_mask_q, fwd_mask_d;
  logic [LineW-1:0]  fwd_data_q;

  logic run, sweep, contend, rf_grant, iv_grant, rd_accept;
  logic [LineW-1:0] w_bits;

  assign run       = (st_q == StRun);
  // Sweep writes are held off while reset is asserted so outputs show reset values.
  assign sweep     = (st_q == StInit) && !reset;
  assign contend   = run && rf_valid && iv_valid;
  assign rf_grant  = run && rf_valid && !(iv_valid && rr_q);
  assign iv_grant  = run && iv_valid && !(rf_valid && !rr_q);
  assign rd_accept = run && rd_valid;

  assign init_done     = run;
  assign rd_ready      = run;
  assign rf_ready      = rf_grant;
  assign iv_ready      = iv_grant;
  assign arr_r_addr    = rd_accept ? rd_set : raddr_q;
  assign rd_resp_valid = resp_q;
  // Forwarded ways take the same-cycle write value; the rest come from the array.
  assign rd_resp_data  = resp_q ? ((fwd_data_q & fwd_mask_q) | (arr_r_data & ~fwd_mask_q))
                                : '0;

  // Write port mux: sweep has the port in INIT, otherwise the granted requester.
  always_comb begin
    arr_w_en     = 1'b0;
    arr_w_addr   = '0;
    arr_w_maskOH = '0;
    arr_w_data   = '0;
    if (sweep) begin
      arr_w_en     = 1'b1;
      arr_w_addr   = init_cnt_q;
      arr_w_maskOH = '1;
    end else if (rf_grant) begin
      arr_w_en     = 1'b1;
      arr_w_addr   = rf_set;
      arr_w_maskOH = WAYS'(1) << rf_way;
      arr_w_data   = {WAYS{rf_data}};
    end else if (iv_grant) begin
      arr_w_en     = 1'b1;
      arr_w_addr   = iv_set;
      arr_w_maskOH = iv_maskOH;
    end
  end

  // Expand the per-way mask to a per-bit mask and capture it on a same-set read/write.
  always_comb begin
    w_bits = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_bits[w*DATA_W +: DATA_W] = {DATA_W{arr_w_maskOH[w]}};
    end
    fwd_mask_d = (rd_accept && arr_w_en && (arr_w_addr == rd_set)) ? w_bits : '0;
  end

  // Next state: sweep counter, RUN entry/exit and round-robin pointer.
  always_comb begin
    st_d       = st_q;
    init_cnt_d = init_cnt_q;
    rr_d       = rr_q;
    unique case (st_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == SetW'(SETS - 1)) begin
          st_d       = StRun;
          init_cnt_d = '0;
        end
      end
      StRun: begin
        // After a contested grant the pointer moves to the loser.
        if (contend) rr_d = ~rr_q;
        if (flush_all) begin
          st_d       = StInit;
          init_cnt_d = '0;
        end
      end
      default: st_d = StInit;
    endcase
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q       <= StInit;
      init_cnt_q <= '0;
      rr_q       <= 1'b0;
      raddr_q    <= '0;
      resp_q     <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      st_q       <= st_d;
      init_cnt_q <= init_cnt_d;
      rr_q       <= rr_d;
      raddr_q    <= arr_r_addr;
      resp_q     <= rd_accept;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= arr_w_data;
    end
  end

endmodule
